bit_rate_meter_scheduler: RTL and testbench

//  Time-shares one bit_rate_meter among CH_NUM data_valid sources. Visits enabled

---
 rtl/bit_rate_meter_scheduler.sv | 106 ++++++++++
 tb/tb_bit_rate_meter_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_rate_meter_scheduler.sv
// Round-robin scheduler that time-shares a single bit_rate_meter among CH_NUM
// data_valid taps and keeps one result register per channel.
module bit_rate_meter_scheduler #(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned RES_WIDTH   = 32,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned MEAS_CYCLES = 1000,
    localparam int unsigned CH_IDX_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                          clk_i,
    input  logic                          s_rst_i,
    input  logic                          en_i,
    input  logic [CH_NUM-1:0]             ch_mask_i,
    input  logic [CH_NUM-1:0]             data_valid_i,
    output logic                          meter_s_rst_n_o,
    output logic                          meter_valid_o,
    input  logic [RES_WIDTH-1:0]          meter_bit_rate_i,
    output logic [CH_NUM*RES_WIDTH-1:0]   bit_rate_o,
    output logic                          rate_valid_o,
    output logic [CH_IDX_W-1:0]           rate_ch_o,
    output logic                          busy_o
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > MEAS_CYCLES) ? RST_CYCLES : MEAS_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_RESET,
        ST_MEASURE,
        ST_CAPTURE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CH_IDX_W-1:0] cur_ch_q;
    logic [CH_IDX_W-1:0] next_ch;
    logic                found;

    // Search starts one past cur_ch and wraps, so the current channel is checked last.
    always_comb begin
        next_ch = cur_ch_q;
        found   = 1'b0;
        for (int unsigned i = 1; i <= CH_NUM; i++) begin
            if (!found && ch_mask_i[CH_IDX_W'((32'(cur_ch_q) + i) % CH_NUM)]) begin
                next_ch = CH_IDX_W'((32'(cur_ch_q) + i) % CH_NUM);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        meter_s_rst_n_o = 1'b0;
        meter_valid_o   = 1'b0;
        busy_o          = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (en_i && |ch_mask_i)
                    state_d = ST_SEL;
            end
            ST_SEL: begin
                state_d = (|ch_mask_i) ? ST_RESET : ST_IDLE;
            end
            ST_RESET: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1))
                    state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                meter_s_rst_n_o = 1'b1;
                meter_valid_o   = data_valid_i[cur_ch_q];
                if (cnt_q == CNT_W'(MEAS_CYCLES - 1))
                    state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                meter_s_rst_n_o = 1'b1;
                state_d         = en_i ? ST_SEL : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cur_ch_q     <= CH_IDX_W'(CH_NUM - 1);
            bit_rate_o   <= '0;
            rate_valid_o <= 1'b0;
            rate_ch_o    <= '0;
        end else begin
            state_q      <= state_d;
            rate_valid_o <= 1'b0;
            cnt_q        <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            if (state_q == ST_SEL && found)
                cur_ch_q <= next_ch;
            if (state_q == ST_CAPTURE) begin
                bit_rate_o[32'(cur_ch_q)*RES_WIDTH +: RES_WIDTH] <= meter_bit_rate_i;
                rate_valid_o <= 1'b1;
                rate_ch_o    <= cur_ch_q;
            end
        end
    end

endmodule

// File: tb/tb_bit_rate_meter_scheduler.sv
// Bench for bit_rate_meter_scheduler with a counting meter stub and a result scoreboard.
module tb_bit_rate_meter_scheduler;

    logic         clk = 1'b0;
    logic         s_rst_i;
    logic         en_i;
    logic [3:0]   ch_mask_i;
    logic [3:0]   dv_one;
    logic [3:0]   dv_tog;
    logic         tog_phase;
    logic [3:0]   data_valid_i;
    logic         meter_s_rst_n_o;
    logic         meter_valid_o;
    logic [31:0]  meter_bit_rate_i;
    logic [127:0] bit_rate_o;
    logic         rate_valid_o;
    logic [1:0]   rate_ch_o;
    logic         busy_o;

    always #5 clk = ~clk;

    assign data_valid_i = dv_one | (dv_tog & {4{tog_phase}});

    bit_rate_meter_scheduler #(
        .CH_NUM(4),
        .RES_WIDTH(32),
        .RST_CYCLES(2),
        .MEAS_CYCLES(8)
    ) dut (
        .clk_i(clk),
        .s_rst_i(s_rst_i),
        .en_i(en_i),
        .ch_mask_i(ch_mask_i),
        .data_valid_i(data_valid_i),
        .meter_s_rst_n_o(meter_s_rst_n_o),
        .meter_valid_o(meter_valid_o),
        .meter_bit_rate_i(meter_bit_rate_i),
        .bit_rate_o(bit_rate_o),
        .rate_valid_o(rate_valid_o),
        .rate_ch_o(rate_ch_o),
        .busy_o(busy_o)
    );

    // Meter stand-in: counts valid cycles since the last reset cycle.
    always @(posedge clk) begin
        if (!meter_s_rst_n_o) meter_bit_rate_i <= '0;
        else if (meter_valid_o) meter_bit_rate_i <= meter_bit_rate_i + 1;
    end

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  one;
        logic [3:0]  tog;
        logic [1:0]  ch0;
        logic [1:0]  ch1;
        logic [31:0] val0;
        logic [31:0] val1;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rate_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got ch %0d want no pulse", rate_ch_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_ch", 32'(rate_ch_o), 32'(e.ch));
                check("pulse_val", bit_rate_o[32'(e.ch)*32 +: 32], e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tog_phase = ~tog_phase;
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] val);
        exp_t e;
        e.ch  = ch;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        en_i    = 1'b0;
        s_rst_i = 1'b1;
        sb.delete();
        tick();
        tick();
        check("rst_busy", 32'(busy_o), 0);
        check("rst_rate_valid", 32'(rate_valid_o), 0);
        check("rst_meter_rst_n", 32'(meter_s_rst_n_o), 0);
        check("rst_bit_rate_nz", 32'(|bit_rate_o), 0);
        s_rst_i = 1'b0;
    endtask

    task automatic wait_sb(input int n, input string name);
        for (int c = 0; c < 400 && sb.size() > n; c++) tick();
        if (sb.size() > n) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending want %0d", name, sb.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 100 && busy_o; c++) tick();
        check(name, 32'(busy_o), 0);
    endtask

    // Lets queued slots drain: en_i drops while the final slot is already running.
    task automatic run_slots(input string name);
        en_i = 1'b1;
        wait_sb(1, name);
        en_i = 1'b0;
        wait_sb(0, name);
        wait_idle({name, "_idle"});
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        int low;
        int pulses;
        int busy_seen;
        logic [31:0] ev;

        vecs[0] = '{mask: 4'b0001, one: 4'b0001, tog: 4'b0000, ch0: 2'd0, ch1: 2'd0, val0: 8, val1: 8};
        vecs[1] = '{mask: 4'b1010, one: 4'b1000, tog: 4'b0010, ch0: 2'd1, ch1: 2'd3, val0: 4, val1: 8};
        vecs[2] = '{mask: 4'b1001, one: 4'b0001, tog: 4'b0000, ch0: 2'd0, ch1: 2'd3, val0: 8, val1: 0};
        vecs[3] = '{mask: 4'b0110, one: 4'b0100, tog: 4'b0010, ch0: 2'd1, ch1: 2'd2, val0: 4, val1: 8};
        vecs[4] = '{mask: 4'b0100, one: 4'b0000, tog: 4'b0100, ch0: 2'd2, ch1: 2'd2, val0: 4, val1: 4};

        tog_phase = 1'b0;
        en_i      = 1'b0;
        s_rst_i   = 1'b1;
        ch_mask_i = '0;
        dv_one    = '0;
        dv_tog    = '0;

        for (int v = 0; v < 5; v++) begin
            do_reset();
            ch_mask_i = vecs[v].mask;
            dv_one    = vecs[v].one;
            dv_tog    = vecs[v].tog;
            for (int s = 0; s < 4; s++) begin
                if (s % 2 == 0) push(vecs[v].ch0, vecs[v].val0);
                else            push(vecs[v].ch1, vecs[v].val1);
            end
            run_slots("vec");
            for (int c = 0; c < 4; c++) begin
                ev = (c == 32'(vecs[v].ch0)) ? vecs[v].val0 :
                     (c == 32'(vecs[v].ch1)) ? vecs[v].val1 : 32'd0;
                check("vec_final", bit_rate_o[c*32 +: 32], ev);
            end
        end

        // Slot period and meter reset duty on a single channel.
        do_reset();
        ch_mask_i = 4'b0001;
        dv_one    = 4'b0001;
        dv_tog    = '0;
        push(2'd0, 8); push(2'd0, 8); push(2'd0, 8);
        en_i = 1'b1;
        for (int c = 0; c < 100 && !rate_valid_o; c++) tick();
        n = 0;
        low = 0;
        do begin
            if (!meter_s_rst_n_o) low++;
            tick();
            n++;
        end while (!rate_valid_o && n < 50);
        check("slot_period", 32'(n), 12);
        check("rst_n_low_cycles", 32'(low), 3);
        en_i = 1'b0;
        wait_sb(0, "period");
        wait_idle("period_idle");

        // en_i dropped mid-MEASURE of ch2.
        do_reset();
        ch_mask_i = 4'b1111;
        dv_one    = 4'b1111;
        push(2'd0, 8); push(2'd1, 8); push(2'd2, 8);
        en_i = 1'b1;
        wait_sb(1, "en_drop");
        for (int c = 0; c < 5; c++) tick();
        en_i = 1'b0;
        wait_sb(0, "en_drop");
        wait_idle("en_drop_idle");
        check("en_drop_meter_valid", 32'(meter_valid_o), 0);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (rate_valid_o) pulses++;
        end
        check("en_drop_no_pulse", 32'(pulses), 0);
        check("en_drop_ch3_untouched", bit_rate_o[96 +: 32], 0);

        // Mask change during ch0 MEASURE takes effect at the next selection.
        do_reset();
        ch_mask_i = 4'b0011;
        dv_one    = 4'b1111;
        push(2'd0, 8); push(2'd2, 8);
        en_i = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        ch_mask_i = 4'b0100;
        wait_sb(1, "mask_chg");
        en_i = 1'b0;
        wait_sb(0, "mask_chg");
        wait_idle("mask_chg_idle");
        check("mask_chg_ch1_skipped", bit_rate_o[32 +: 32], 0);
        check("mask_chg_ch2", bit_rate_o[64 +: 32], 8);

        // Reset during MEASURE of ch1 restarts the search from channel 0.
        do_reset();
        ch_mask_i = 4'b0110;
        dv_one    = 4'b1111;
        push(2'd1, 8); push(2'd2, 8);
        en_i = 1'b1;
        wait_sb(0, "mid_rst");
        for (int c = 0; c < 5; c++) tick();
        check("mid_rst_pre_meter_valid", 32'(meter_valid_o), 1);
        s_rst_i = 1'b1;
        tick();
        check("mid_rst_bit_rate", 32'(|bit_rate_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_rate_valid", 32'(rate_valid_o), 0);
        check("mid_rst_rate_ch", 32'(rate_ch_o), 0);
        check("mid_rst_meter_rst_n", 32'(meter_s_rst_n_o), 0);
        check("mid_rst_meter_valid", 32'(meter_valid_o), 0);
        tick();
        s_rst_i = 1'b0;
        push(2'd1, 8); push(2'd2, 8);
        wait_sb(1, "post_rst");
        en_i = 1'b0;
        wait_sb(0, "post_rst");
        wait_idle("post_rst_idle");

        // Enabled with an empty mask never leaves IDLE.
        do_reset();
        ch_mask_i = 4'b0000;
        en_i      = 1'b1;
        pulses    = 0;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rate_valid_o) pulses++;
            if (busy_o) busy_seen++;
        end
        check("empty_mask_busy", 32'(busy_seen), 0);
        check("empty_mask_pulses", 32'(pulses), 0);
        en_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
